// File: rtl/circle_lines_stream.sv
// circle_lines_stream: midpoint-circle generator that streams span or point tuples over valid/ready.
// Define CIRCLE_LINES_STREAM_COUNT_EN to add the _count transfer counter output.
module circle_lines_stream #(
  parameter int WIDTH = 32,
  parameter int MODE = 0
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] cx,
  input  logic signed [WIDTH-1:0] cy,
  input  logic signed [WIDTH-1:0] r,
  input  logic                    _ready,
  output logic                    _valid,
  output logic signed [WIDTH-1:0] _out0,
  output logic signed [WIDTH-1:0] _out1,
  output logic signed [WIDTH-1:0] _out2,
  output logic signed [WIDTH-1:0] _out3,
  output logic                    _done
`ifdef CIRCLE_LINES_STREAM_COUNT_EN
  ,
  output logic [WIDTH-1:0]        _count
`endif
);
  localparam int DW = WIDTH + 4;
  localparam logic [2:0] LAST = (MODE == 0) ? 3'd3 : 3'd7;
  typedef enum logic [2:0] {IDLE, INIT, EMIT, STEP, DONE} state_t;
  state_t state, state_n;
  logic signed [WIDTH-1:0] lcx, lcy, lr, x, y, x_n, y_n, a, b, t0, t1, t2;
  logic signed [DW-1:0] d, d_n, rx, xx, yx;
  logic [2:0] k, k_n;
  logic xfer, load, dpos, sw, neg_y;
  assign rx = lr;
  assign xx = x;
  assign yx = y;
  assign xfer = _valid & _ready;
  assign dpos = !d[DW-1] && (d != '0);
  assign _valid = state == EMIT;
  assign _done = state == DONE;
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    d_n = d;
    k_n = k;
    load = 1'b0;
    case (state)
      INIT: begin
        x_n = '0;
        y_n = lr;
        d_n = DW'(3) - (rx <<< 1);
        k_n = '0;
        load = !lr[WIDTH-1];
        state_n = load ? EMIT : DONE;
      end
      EMIT: if (xfer) begin
        k_n = k + 3'd1;
        load = k != LAST;
        state_n = load ? EMIT : STEP;
      end
      STEP: begin
        x_n = x + 1'b1;
        y_n = dpos ? y - 1'b1 : y;
        d_n = dpos ? d + ((xx - yx) <<< 2) + DW'(10) : d + (xx <<< 2) + DW'(6);
        k_n = '0;
        load = y_n >= x_n;
        state_n = load ? EMIT : DONE;
      end
      default: ;
    endcase
    if (_start) state_n = INIT;
  end
  // The tuple loaded next is built from the post-update loop values and index.
  assign sw = (MODE == 0) ? k_n[1] : k_n[2];
  assign neg_y = (MODE == 0) ? k_n[0] : k_n[1];
  assign a = sw ? y_n : x_n;
  assign b = sw ? x_n : y_n;
  assign t0 = (MODE == 0 || k_n[0]) ? lcx - a : lcx + a;
  assign t1 = neg_y ? lcy - b : lcy + b;
  assign t2 = (MODE == 0) ? lcx + a : t0;
  always_ff @(posedge _clock) state <= _reset ? IDLE : state_n;
  always_ff @(posedge _clock) begin
    if (_reset) begin
      {lcx, lcy, lr, x, y, d, k} <= '0;
      {_out0, _out1, _out2, _out3} <= '0;
    end else if (_start) begin
      lcx <= cx;
      lcy <= cy;
      lr <= r;
    end else begin
      x <= x_n;
      y <= y_n;
      d <= d_n;
      k <= k_n;
      if (load) begin
        _out0 <= t0;
        _out1 <= t1;
        _out2 <= t2;
        _out3 <= t1;
      end
    end
  end
`ifdef CIRCLE_LINES_STREAM_COUNT_EN
  always_ff @(posedge _clock) _count <= (_reset || _start) ? '0 : _count + WIDTH'(xfer);
`endif
endmodule

// File: tb/tb_circle_lines_stream.sv
// tb_circle_lines_stream: directed and random runs of both modes against an event-list reference model.
module tb_circle_lines_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, ready;
  logic signed [31:0] cx, cy, r;
  logic v0, d0, v1, d1;
  logic signed [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
`ifdef CIRCLE_LINES_STREAM_COUNT_EN
  logic [31:0] c0, c1;
`endif
  circle_lines_stream #(.WIDTH(32), .MODE(0)) u0 (
    ._clock(clk), ._reset(rst), ._start(start), .cx(cx), .cy(cy), .r(r), ._ready(ready),
    ._valid(v0), ._out0(a0), ._out1(a1), ._out2(a2), ._out3(a3), ._done(d0)
`ifdef CIRCLE_LINES_STREAM_COUNT_EN
    , ._count(c0)
`endif
  );
  circle_lines_stream #(.WIDTH(32), .MODE(1)) u1 (
    ._clock(clk), ._reset(rst), ._start(start), .cx(cx), .cy(cy), .r(r), ._ready(ready),
    ._valid(v1), ._out0(b0), ._out1(b1), ._out2(b2), ._out3(b3), ._done(d1)
`ifdef CIRCLE_LINES_STREAM_COUNT_EN
    , ._count(c1)
`endif
  );
  // Each run is a list of cycle slots: a bubble lasts one cycle, a tuple lasts until accepted.
  typedef struct packed {
    logic tup;
    logic [3:0][31:0] t;
  } ev_t;
  ev_t q0[$], q1[$];
  ev_t last0, last1;
  int nc = 0, nf = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nc++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic ev_t tu(input int p0, input int p1, input int p2, input int p3);
    ev_t e;
    e.tup = 1'b1;
    e.t[0] = p0;
    e.t[1] = p1;
    e.t[2] = p2;
    e.t[3] = p3;
    return e;
  endfunction
  function automatic void build(input int acx, input int acy, input int ar);
    int x, y;
    longint d;
    ev_t bub;
    bub = '0;
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    q0.push_back(bub);
    q1.push_back(bub);
    x = 0;
    y = ar;
    d = 3 - 2 * longint'(ar);
    while (y >= x) begin
      q0.push_back(tu(acx - x, acy + y, acx + x, acy + y));
      q0.push_back(tu(acx - x, acy - y, acx + x, acy - y));
      q0.push_back(tu(acx - y, acy + x, acx + y, acy + x));
      q0.push_back(tu(acx - y, acy - x, acx + y, acy - x));
      q1.push_back(tu(acx + x, acy + y, acx + x, acy + y));
      q1.push_back(tu(acx - x, acy + y, acx - x, acy + y));
      q1.push_back(tu(acx + x, acy - y, acx + x, acy - y));
      q1.push_back(tu(acx - x, acy - y, acx - x, acy - y));
      q1.push_back(tu(acx + y, acy + x, acx + y, acy + x));
      q1.push_back(tu(acx - y, acy + x, acx - y, acy + x));
      q1.push_back(tu(acx + y, acy - x, acx + y, acy - x));
      q1.push_back(tu(acx - y, acy - x, acx - y, acy - x));
      last0 = q0[q0.size()-1];
      last1 = q1[q1.size()-1];
      q0.push_back(bub);
      q1.push_back(bub);
      if (d > 0) begin
        d += 4 * (longint'(x) - y) + 10;
        y--;
      end else d += 4 * longint'(x) + 6;
      x++;
    end
  endfunction
  task automatic side(input string s, input ev_t e, input bit fin, input ev_t last, input logic v, input logic dn, input logic [127:0] o);
    chk({s, " valid"}, 128'(v), 128'(e.tup));
    chk({s, " done"}, 128'(dn), 128'(fin));
    if (e.tup) chk({s, " tuple"}, o, e.t);
    else if (fin && last.tup) chk({s, " hold"}, o, last.t);
  endtask
  task automatic run(input int acx, input int acy, input int ar, input int rm, input int lim, input bit full);
    int i0, i1, x0c, x1c;
    logic rd;
    ev_t e0, e1;
    build(acx, acy, ar);
    @(negedge clk);
    cx = acx;
    cy = acy;
    r = ar;
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    i0 = 0;
    i1 = 0;
    x0c = 0;
    x1c = 0;
    side("m0", q0[0], 1'b0, last0, v0, d0, {a3, a2, a1, a0});
    side("m1", q1[0], 1'b0, last1, v1, d1, {b3, b2, b1, b0});
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      ready = (rm == 0) ? 1'b1 : (rm == 1) ? ($urandom_range(0, 3) != 0) : !(c == 3 || c == 4);
      rd = ready;
      @(posedge clk);
      if (i0 < q0.size() && (!q0[i0].tup || rd)) begin
        x0c += int'(q0[i0].tup);
        i0++;
      end
      if (i1 < q1.size() && (!q1[i1].tup || rd)) begin
        x1c += int'(q1[i1].tup);
        i1++;
      end
      #1;
      e0 = (i0 < q0.size()) ? q0[i0] : '0;
      e1 = (i1 < q1.size()) ? q1[i1] : '0;
      side("m0", e0, i0 >= q0.size(), last0, v0, d0, {a3, a2, a1, a0});
      side("m1", e1, i1 >= q1.size(), last1, v1, d1, {b3, b2, b1, b0});
`ifdef CIRCLE_LINES_STREAM_COUNT_EN
      chk("m0 count", 128'(c0), 128'(x0c));
      chk("m1 count", 128'(c1), 128'(x1c));
`endif
      if (i0 >= q0.size() && i1 >= q1.size()) break;
    end
    if (full) chk("run end done", 128'({d0, d1}), 128'(2'b11));
  endtask
  task automatic rst_chk(input string s);
    chk({s, " valid"}, 128'({v0, v1}), 128'(0));
    chk({s, " done"}, 128'({d0, d1}), 128'(0));
    chk({s, " out m0"}, {a3, a2, a1, a0}, 128'(0));
    chk({s, " out m1"}, {b3, b2, b1, b0}, 128'(0));
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    cx = '0;
    cy = '0;
    r = '0;
    repeat (2) @(posedge clk);
    #1 rst_chk("reset");
    @(negedge clk) rst = 1'b0;
    run(10, 20, 1, 0, 200, 1'b1);
    run(0, 0, 2, 0, 200, 1'b1);
    run(0, 0, -5, 0, 200, 1'b1);
    run(0, 0, 2, 2, 200, 1'b1);
    run(5, 5, 0, 0, 200, 1'b1);
    run(32'h7fff_fffe, 32'h8000_0001, 3, 0, 400, 1'b1);
    for (int n = 0; n < 6; n++) run(int'($urandom), int'($urandom), int'($urandom_range(0, 18)) - 3, 1, 2000, 1'b1);
    run(3, -4, 7, 1, 6, 1'b0);
    run(-7, 9, 4, 1, 2000, 1'b1);
    run(1, 2, 6, 0, 7, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst_chk("midrst");
    @(posedge clk);
    #1 rst_chk("midrst2");
    @(negedge clk) rst = 1'b0;
    run(10, 20, 1, 0, 200, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
